// File: rtl/keypad_number_entry_if.sv
// Result hand-off channel between the keypad entry buffer and the CPU I/O side.
// The master presents a converted value and holds it until the slave accepts it.
interface keypad_number_entry_if #(
    parameter int OUT_W = 32
);
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] result;
    logic                    result_ovf;

    modport master (
        output out_valid,
        output result,
        output result_ovf,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  result,
        input  result_ovf,
        output out_ready
    );
endinterface

// File: rtl/keypad_number_entry.sv
// Keypad number-entry buffer: press-edge detection, right-aligned BCD editing,
// and a fixed-latency BCD-to-binary conversion with sign and saturation.
module keypad_number_entry #(
    parameter int DIGITS = 8,
    parameter int OUT_W  = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [3:0]                   key_code_i,
    output logic [4*DIGITS-1:0]          disp_bcd_o,
    output logic [$clog2(DIGITS+1)-1:0]  digit_cnt_o,
    output logic                         neg_o,
    output logic                         full_o,
    output logic                         busy_o,
    keypad_number_entry_if.master        out_if
);

    localparam int CNT_W = $clog2(DIGITS+1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int AW    = OUT_W + 4;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGITS);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
    localparam logic [AW-1:0]    LIM_NEG = AW'(1) << (OUT_W - 1);
    localparam logic [AW-1:0]    LIM_POS = LIM_NEG - AW'(1);

    typedef enum logic [1:0] {
        EDIT = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              key_prev_q, key_prev_d;
    logic [4*DIGITS-1:0]     bcd_q, bcd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    neg_q, neg_d;
    logic [AW-1:0]           acc_q, acc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    ovf_q, ovf_d;
    logic                    valid_q, valid_d;
    logic signed [OUT_W-1:0] result_q, result_d;
    logic                    rovf_q, rovf_d;

    logic                    key_ev;
    logic                    full;
    logic [4*DIGITS+3:0]     bcd_ext;
    logic [3:0]              nib;
    logic [AW-1:0]           lim;
    logic [AW:0]             step;

    // One multiply-accumulate step; the MSB flags that the limit was hit.
    function automatic logic [AW:0] mac_sat(input logic [AW-1:0] acc,
                                            input logic [3:0]    dig,
                                            input logic [AW-1:0] limit);
        logic [AW-1:0] v;
        v = (acc << 3) + (acc << 1) + {{(AW-4){1'b0}}, dig};
        if (v > limit) return {1'b1, limit};
        return {1'b0, v};
    endfunction

    // The clamped negative magnitude 2^(OUT_W-1) wraps to itself on negation.
    function automatic logic signed [OUT_W-1:0] apply_sign(input logic [OUT_W-1:0] mag,
                                                           input logic             is_neg);
        logic signed [OUT_W-1:0] m;
        m = $signed(mag);
        return is_neg ? -m : m;
    endfunction

    assign key_ev  = (key_code_i != 4'hF) && (key_prev_q == 4'hF);
    assign full    = (cnt_q == CNT_MAX);
    assign bcd_ext = {bcd_q, key_code_i};
    assign nib     = 4'(bcd_q >> {idx_q, 2'b00});
    assign lim     = neg_q ? LIM_NEG : LIM_POS;
    assign step    = mac_sat(acc_q, nib, lim);

    always_comb begin
        state_d    = state_q;
        key_prev_d = key_code_i;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        ovf_d      = ovf_q;
        valid_d    = valid_q;
        result_d   = result_q;
        rovf_d     = rovf_q;

        case (state_q)
            EDIT: begin
                if (key_ev) begin
                    if (key_code_i <= 4'd9) begin
                        if (!full) begin
                            bcd_d = bcd_ext[4*DIGITS-1:0];
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        case (key_code_i)
                            4'hA: begin
                                state_d = CONV;
                                acc_d   = '0;
                                idx_d   = IDX_MAX;
                                ovf_d   = 1'b0;
                            end
                            4'hB: begin
                                bcd_d = '0;
                                cnt_d = '0;
                                neg_d = 1'b0;
                            end
                            4'hC: begin
                                if (cnt_q != '0) begin
                                    bcd_d = bcd_q >> 4;
                                    cnt_d = cnt_q - CNT_W'(1);
                                end
                            end
                            4'hD: neg_d = ~neg_q;
                            default: ;
                        endcase
                    end
                end
            end
            // Walk every nibble from the top so latency never depends on digit_cnt.
            CONV: begin
                acc_d = step[AW-1:0];
                ovf_d = ovf_q | step[AW];
                idx_d = idx_q - IDX_W'(1);
                if (idx_q == '0) begin
                    state_d  = DONE;
                    result_d = apply_sign(step[OUT_W-1:0], neg_q);
                    rovf_d   = ovf_q | step[AW];
                    valid_d  = 1'b1;
                end
            end
            DONE: begin
                if (out_if.out_ready) begin
                    state_d = EDIT;
                    valid_d = 1'b0;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    neg_d   = 1'b0;
                end
            end
            default: state_d = EDIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= EDIT;
            key_prev_q <= 4'hF;
            bcd_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            acc_q      <= '0;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            rovf_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= key_prev_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            rovf_q     <= rovf_d;
        end
    end

    assign disp_bcd_o        = bcd_q;
    assign digit_cnt_o       = cnt_q;
    assign neg_o             = neg_q;
    assign full_o            = full;
    assign busy_o            = (state_q != EDIT);
    assign out_if.out_valid  = valid_q;
    assign out_if.result     = result_q;
    assign out_if.result_ovf = rovf_q;

endmodule

// File: doc/keypad_number_entry.md
# keypad_number_entry

Clocked, parametrised keypad number-entry buffer. It takes raw 4-bit key codes from the keypad scanner and detects press edges. It maintains a right-aligned BCD entry of up to DIGITS decimal digits, with backspace, clear and sign toggle. On the enter key it converts the entry into a saturated two's-complement binary word and hands it to the CPU I/O side over a valid/ready handshake.

## Interface
- DIGITS, 8: maximum number of decimal digits held (≥1).
- OUT_W, 32: width of the binary result (≥8).
- clk  in  1  system clock, all state updates on rising edge.
- rstn  in  1  reset rstn, synchronous, active-low.
- key_code  in  4  scanner code; 4'hF = no key pressed.
- out_ready  in  1  consumer accepts result.
- disp_bcd  out  4*DIGITS  entered digits, most recent digit in [3:0], unused nibbles 0.
- digit_cnt  out  $clog2(DIGITS+1)  digits currently entered.
- neg  out  1  sign flag of the entry.
- full  out  1  digit_cnt == DIGITS.
- busy  out  1  high in CONV and DONE states.
- out_valid  out  1  result valid, held until accepted.
- result  out  OUT_W  converted signed value.
- result_ovf  out  1  magnitude was saturated during the last conversion.

## Operation
- Key event: key_prev register, reset to 4'hF. An event fires on an edge where key_code != 4'hF and key_prev == 4'hF.
  - A held key gives one event.
  - A direct change between two non-idle codes gives no event.
  - key_prev updates every cycle in every state.
- Codes:
  - 0x0–0x9: digit.
  - 0xA: enter.
  - 0xB: clear.
  - 0xC: backspace.
  - 0xD: toggle neg.
  - 0xE: ignored.
- States:
  - EDIT: handles key events.
  - CONV: runs the conversion.
  - DONE: presents the result.
  - Key events are discarded in CONV and DONE.
- EDIT, digit: if !full, disp_bcd <= {disp_bcd[4*DIGITS-5:0], code} and digit_cnt+1. If full, the digit is ignored and nothing changes.
- EDIT, backspace: if digit_cnt > 0, disp_bcd >>= 4 and digit_cnt−1. If digit_cnt == 0, no-op.
- EDIT, clear: disp_bcd, digit_cnt and neg are set to 0.
- EDIT, toggle: neg <= ~neg.
- EDIT, enter, with any digit_cnt including 0:
  - Go to CONV.
  - acc <= 0, idx <= DIGITS−1, sticky ovf <= 0.
- CONV, each edge:
  - acc <= acc*10 + disp_bcd[4*idx+:4], then idx−1.
  - Limit L = 2^(OUT_W−1) if neg, else 2^(OUT_W−1)−1. If the new acc > L, set ovf and clamp acc to L. This keeps acc within OUT_W+4 bits.
  - On the edge processing idx 0, go to DONE. At the same edge, load result = neg ? −acc : acc (OUT_W bits), result_ovf = ovf, out_valid = 1.
- DONE: out_valid stays high and result is stable until an edge with out_ready = 1. At that edge:
  - out_valid <= 0.
  - disp_bcd, digit_cnt and neg are cleared.
  - Go to EDIT.
  - result and result_ovf keep their value until the next conversion.
- −0 converts to 0 with result_ovf = 0.

## Timing
- Reset values:
  - disp_bcd, digit_cnt, neg, full, busy, out_valid, result and result_ovf are 0.
  - State is EDIT and key_prev is 4'hF.
  - A key held through reset release produces one event on the first edge after release.
- Edit latency: with an event at edge E, disp_bcd, digit_cnt, neg and full are updated in the cycle after E.
- Conversion latency: with enter at edge E0, busy is high from E0+1. out_valid and result are visible after edge E0+DIGITS. The latency is fixed and independent of digit_cnt.
- Handshake: the transfer occurs on an edge with out_valid & out_ready. The earliest acceptance is the first cycle out_valid is high. out_ready while not in DONE is ignored.
- Reset asserted mid-conversion or in DONE returns every output to its reset value at that edge. No result is delivered.
- full is combinational from digit_cnt, registered through digit_cnt.

## Test plan
- Digit entry: press 1,2,3 (each followed by 4'hF) -> disp_bcd = 0x00000123, digit_cnt = 3. Then hold 4 for 5 cycles -> a single digit, disp_bcd = 0x00001234.
- Edit keys:
  - Enter 5,6,7, then backspace -> 0x56, cnt 2.
  - Backspace ×3 -> 0, cnt 0, no underflow.
  - Enter 9, then clear -> all 0.
  - Code change 4'h3 -> 4'h4 with no idle between -> no event.
- Full buffer: enter 9 digits 1..9 with DIGITS = 8 -> disp_bcd = 0x12345678, full = 1, digit 9 ignored.
- Conversion and handshake: enter 1,2,3,4, toggle, enter, out_ready low:
  - busy goes high.
  - After exactly 8 cycles out_valid = 1, result = −1234 (0xFFFFFB2E), result_ovf = 0.
  - out_valid is held while out_ready is low.
  - out_ready pulse -> out_valid 0, buffer cleared, result retained.
- Saturation with OUT_W = 16:
  - 99999 -> result = 32767, result_ovf = 1.
  - 32768 negative -> result = −32768 (0x8000), result_ovf = 0.
  - 32768 positive -> 32767, result_ovf = 1.
  - Empty enter -> result = 0 after DIGITS cycles.
- Reset and ignored keys: assert rstn low during CONV -> next cycle all outputs are 0 and state is EDIT. Key events pressed during CONV/DONE do not alter disp_bcd.
